instruction_fetch: RTL and testbench

//  Front stage of the Mini-MIPS cpu. Holds the PC and issues word reads to instruction memory

---
 rtl/instruction_fetch_pkg.sv | 33 +++
 rtl/instruction_fetch_if.sv | 53 +++++
 rtl/instruction_fetch_fifo.sv | 71 +++++++
 rtl/instruction_fetch.sv | 171 +++++++++++++++++
 tb/tb_instruction_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
//   Shared definitions for the Mini-MIPS instruction fetch stage:
//   word width, PC increment, fetch FSM state encodings, the debug
//   snapshot struct exposed by the top, and a word-alignment helper.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;

  // Fetch FSM encodings (IF_IDLE/IF_REQ/IF_WAIT/IF_DROP).
  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_DROP = 2'd3
  } if_state_e;

  // Debug snapshot: current FSM state, FIFO occupancy and whether the
  // current cycle discards an in-flight memory response.
  typedef struct packed {
    if_state_e  state;
    logic [7:0] fifo_count;
    logic       drop_resp;
  } if_dbg_t;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
//   Bundle of every non-clock signal of the fetch stage.
//   master : the fetch stage (drives imem request, decode output, perf)
//   slave  : its environment (memory, decode, execute redirect)
//
// Handshake semantics:
//   imem  : a request transfers on a rising edge where imem_req & imem_ready.
//           The responder returns exactly one imem_rvalid pulse per accepted
//           request, in order, with at most one request outstanding.
//   decode: an entry transfers on a rising edge where dec_valid & dec_ready;
//           dec_valid never depends combinationally on dec_ready.
//   redirect_valid is a single-cycle command sampled on the rising edge.
// -----------------------------------------------------------------------------
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [WORD_W-1:0] imem_rdata;

  logic              dec_valid;
  logic              dec_ready;
  logic [WORD_W-1:0] dec_pc;
  logic [WORD_W-1:0] dec_instr;

  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_pc;

  logic [WORD_W-1:0] perf_fetched;
  logic [WORD_W-1:0] perf_flushed;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output dec_valid, dec_pc, dec_instr,
    input  dec_ready,
    input  redirect_valid, redirect_pc,
    output perf_fetched, perf_flushed
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  dec_valid, dec_pc, dec_instr,
    output dec_ready,
    output redirect_valid, redirect_pc,
    input  perf_fetched, perf_flushed
  );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous prefetch FIFO holding {pc, instr} pairs.
//   Ports:
//     clock, reset     : rising-edge clock, async active-low reset
//     i_push, i_wdata  : write an entry (ignored when full)
//     i_pop            : drop the head entry (ignored when empty)
//     i_clear          : empty the FIFO; wins over push and pop
//     o_rdata          : head entry (meaningful only when !o_empty)
//     o_full, o_empty  : occupancy flags
//     o_count          : number of stored entries
//   DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset: nothing reads it while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Front stage of the Mini-MIPS cpu. Holds the PC, issues word reads to
//   instruction memory, buffers returned {pc, instr} pairs in a prefetch FIFO
//   and hands them to decode. Execute redirects it on taken branches/jumps.
//
//   Parameters:
//     RESET_PC   : PC of the first fetch after reset
//     FIFO_DEPTH : prefetch entries (power of 2, >= 2)
//   Ports:
//     clock      : rising-edge clock
//     reset      : asynchronous, active-low
//     bus        : instruction_fetch_if.master (imem, decode, redirect, perf)
//     o_dbg      : FSM state, FIFO occupancy, response-drop strobe
//
//   Build option: define FETCH_PERF_EN to add the perf_fetched/perf_flushed
//   counters; without it both perf outputs are constant zero.
// -----------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  instruction_fetch_if.master  bus,
  output if_dbg_t              o_dbg
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if_state_e         r_state;
  if_state_e         w_state_nxt;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_req_addr;

  logic              w_req;
  logic              w_accept;
  logic              w_push;
  logic              w_drop_resp;
  logic              w_redirect;
  logic [WORD_W-1:0] w_redirect_pc;

  logic [63:0]       w_fifo_rdata;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;

  assign w_redirect    = bus.redirect_valid;
  assign w_redirect_pc = word_align(bus.redirect_pc);
  assign w_accept      = w_req && bus.imem_ready;

  // ---------------------------------------------------------------------------
  // Fetch FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IF_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM: next state and per-cycle strobes
  //   The request is only raised when a FIFO slot is free for its response.
  //   Since a push only happens in WAIT, occupancy cannot grow while a
  //   request is being held, so req never drops before it is accepted
  //   (a redirect may still move the address).
  //   A response that lands in the same cycle as a redirect is discarded and
  //   the FSM returns to REQ, as nothing remains in flight afterwards.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_push      = 1'b0;
    w_drop_resp = 1'b0;
    unique case (r_state)
      IF_IDLE: w_state_nxt = IF_REQ;
      IF_REQ: begin
        w_req = !w_full;
        if (w_req && bus.imem_ready) begin
          // An accepted request coinciding with a redirect is already stale.
          w_state_nxt = w_redirect ? IF_DROP : IF_WAIT;
          w_drop_resp = w_redirect;
        end
      end
      IF_WAIT: begin
        if (w_redirect) begin
          w_drop_resp = 1'b1;
          w_state_nxt = bus.imem_rvalid ? IF_REQ : IF_DROP;
        end else if (bus.imem_rvalid) begin
          w_push      = 1'b1;
          w_state_nxt = IF_REQ;
        end
      end
      IF_DROP: begin
        if (bus.imem_rvalid) w_state_nxt = IF_REQ;
      end
      default: w_state_nxt = IF_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC and request-address tracking. r_req_addr remembers the address of the
  // outstanding request so the response can be tagged with its own PC.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc       <= word_align(RESET_PC);
      r_req_addr <= '0;
    end else begin
      if (w_accept) r_req_addr <= r_pc;
      if (w_redirect)    r_pc <= w_redirect_pc;
      else if (w_accept) r_pc <= r_pc + PC_INC;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO. A redirect clears it, including an entry handed to decode
  // in that same cycle.
  // ---------------------------------------------------------------------------
  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata ({r_req_addr, bus.imem_rdata}),
    .i_pop   (bus.dec_ready),
    .i_clear (w_redirect),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;
  assign bus.dec_valid = !w_empty;
  // Head fields read as zero while nothing is buffered.
  assign bus.dec_pc    = w_empty ? '0 : w_fifo_rdata[63:32];
  assign bus.dec_instr = w_empty ? '0 : w_fifo_rdata[31:0];

  assign o_dbg = '{state: r_state, fifo_count: 8'(w_count), drop_resp: w_drop_resp};

  // ---------------------------------------------------------------------------
  // Performance counters (wrap naturally at 2^32).
  // perf_flushed adds the entries cleared plus one for a discarded response.
  // ---------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
  logic [WORD_W-1:0] r_perf_fetched;
  logic [WORD_W-1:0] r_perf_flushed;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
    end else begin
      if (w_push)     r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_redirect) r_perf_flushed <= r_perf_flushed + 32'(w_count) + 32'(w_drop_resp);
    end
  end

  assign bus.perf_fetched = r_perf_fetched;
  assign bus.perf_flushed = r_perf_flushed;
`else
  assign bus.perf_fetched = '0;
  assign bus.perf_flushed = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed bench for instruction_fetch. A memory model answers requests
//   with data = addr ^ 32'hA5A5_0000 after a programmable latency and checks
//   every accepted address against addr_exp_q; a decode monitor checks every
//   handed-off {pc, instr} pair against exp_q.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  instruction_fetch_if bus();
  if_dbg_t dbg;

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .o_dbg (dbg)
  );

  // Environment controls
  bit   mem_ready_en;
  int   accept_left;
  int   mem_lat;
  logic dec_ready_r;

  assign bus.imem_ready = mem_ready_en && (accept_left > 0);
  assign bus.dec_ready  = dec_ready_r;

  // Scoreboard state
  int          n_tests;
  int          n_fail;
  logic [63:0] exp_q[$];
  logic [31:0] addr_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic exp_fetch(input logic [31:0] pc, input logic [31:0] instr);
    addr_exp_q.push_back(pc);
    exp_q.push_back({pc, instr});
  endtask

  task automatic do_reset();
    reset              = 1'b0;
    mem_ready_en       = 1'b0;
    accept_left        = 0;
    mem_lat            = 0;
    dec_ready_r        = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || addr_exp_q.size() != 0) && c < max) begin
      tick();
      c++;
    end
    check(name, 32'(exp_q.size() + addr_exp_q.size()), 32'd0);
    exp_q.delete();
    addr_exp_q.delete();
  endtask

  task automatic wait_for(input string name, input if_state_e s, input int cnt, input int max);
    int c;
    c = 0;
    while (!(dbg.state == s && int'(dbg.fifo_count) == cnt) && c < max) begin
      tick();
      c++;
    end
    check(name, 32'(c < max), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Memory model + address scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    logic        acc;
    logic [31:0] a;
    bit          pend;
    int          wait_cnt;
    logic [31:0] pend_addr;
    pend            = 1'b0;
    wait_cnt        = 0;
    pend_addr       = '0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clock);
      acc = bus.imem_req && bus.imem_ready;
      a   = bus.imem_addr;
      #1;
      bus.imem_rvalid = 1'b0;
      if (!reset) begin
        pend = 1'b0;
      end else begin
        if (acc) begin
          if (addr_exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL imem_addr_unexpected: got %h expected none", a);
          end else begin
            check("imem_addr", a, addr_exp_q.pop_front());
          end
          accept_left--;
          pend      = 1'b1;
          pend_addr = a;
          wait_cnt  = mem_lat;
        end
        if (pend) begin
          if (wait_cnt == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = pend_addr ^ DATA_KEY;
            pend            = 1'b0;
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decode monitor
  // ---------------------------------------------------------------------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clock);
      if (reset && bus.dec_valid && bus.dec_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dec_unexpected: got pc %h instr %h expected none", bus.dec_pc, bus.dec_instr);
        end else begin
          e = exp_q.pop_front();
          check("dec_pc", bus.dec_pc, e[63:32]);
          check("dec_instr", bus.dec_instr, e[31:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset state
    do_reset();
    reset = 1'b0;
    tick();
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("rst_dec_pc", bus.dec_pc, 32'd0);
    check("rst_dec_instr", bus.dec_instr, 32'd0);
    check("rst_state", 32'(dbg.state), 32'(IF_IDLE));
    check("rst_perf_fetched", bus.perf_fetched, 32'd0);
    check("rst_perf_flushed", bus.perf_flushed, 32'd0);

    // 1: streaming fetch with single-cycle memory
    do_reset();
    mem_ready_en = 1'b1;
    accept_left  = 6;
    dec_ready_r  = 1'b1;
    for (int i = 0; i < 6; i++) exp_fetch(32'(i * 4), 32'(i * 4) ^ DATA_KEY);
    wait_drain("t1_drain", 40);
    repeat (2) tick();
    check("t1_dec_valid_idle", 32'(bus.dec_valid), 32'd0);
    check("t1_req_held", 32'(bus.imem_req), 32'd1);
    check("t1_next_addr", bus.imem_addr, 32'h0000_0018);
    check("t1_state", 32'(dbg.state), 32'(IF_REQ));

    // 2: decode stalled -> FIFO fills, then drains in order and fetch resumes
    do_reset();
    mem_ready_en = 1'b1;
    accept_left  = 6;
    exp_fetch(32'h0000_0000, 32'hA5A5_0000);
    exp_fetch(32'h0000_0004, 32'hA5A5_0004);
    exp_fetch(32'h0000_0008, 32'hA5A5_0008);
    exp_fetch(32'h0000_000C, 32'hA5A5_000C);
    exp_fetch(32'h0000_0010, 32'hA5A5_0010);
    exp_fetch(32'h0000_0014, 32'hA5A5_0014);
    repeat (14) tick();
    check("t2_req_full", 32'(bus.imem_req), 32'd0);
    check("t2_count_full", 32'(dbg.fifo_count), 32'd4);
    check("t2_dec_valid", 32'(bus.dec_valid), 32'd1);
    check("t2_head_pc", bus.dec_pc, 32'h0000_0000);
    dec_ready_r = 1'b1;
    wait_drain("t2_drain", 40);

    // 3: redirect while a response is in flight
    do_reset();
    mem_ready_en = 1'b1;
    accept_left  = 2;
    dec_ready_r  = 1'b1;
    exp_fetch(32'h0000_0000, 32'hA5A5_0000);
    exp_fetch(32'h0000_0004, 32'hA5A5_0004);
    wait_drain("t3_pre_drain", 20);
    dec_ready_r = 1'b0;
    mem_lat     = 2;
    addr_exp_q.push_back(32'h0000_0008);
    accept_left = 1;
    wait_for("t3_wait_state", IF_WAIT, 0, 10);
    exp_fetch(32'h0000_0100, 32'hA5A5_0100);
    accept_left        = 1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    #1;
    check("t3_drop_strobe", 32'(dbg.drop_resp), 32'd1);
    tick();
    bus.redirect_valid = 1'b0;
    check("t3_state_drop", 32'(dbg.state), 32'(IF_DROP));
    check("t3_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("t3_req_in_drop", 32'(bus.imem_req), 32'd0);
    dec_ready_r = 1'b1;
    wait_drain("t3_drain", 30);

    // 4: memory not ready for 5 cycles, redirect in cycle 3
    do_reset();
    dec_ready_r = 1'b1;
    wait_for("t4_req_state", IF_REQ, 0, 5);
    for (int c = 1; c <= 5; c++) begin
      check("t4_req_held", 32'(bus.imem_req), 32'd1);
      check("t4_addr", bus.imem_addr, (c < 4) ? 32'h0000_0000 : 32'h0000_0200);
      if (c == 3) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
      end
      tick();
      bus.redirect_valid = 1'b0;
    end
    exp_fetch(32'h0000_0200, 32'hA5A5_0200);
    accept_left  = 1;
    mem_ready_en = 1'b1;
    wait_drain("t4_drain", 20);

    // 5: PC wraps from FFFF_FFFC to 0
    do_reset();
    dec_ready_r = 1'b1;
    wait_for("t5_req_state", IF_REQ, 0, 5);
    redirect(32'hFFFF_FFFE);
    check("t5_aligned_addr", bus.imem_addr, 32'hFFFF_FFFC);
    exp_fetch(32'hFFFF_FFFC, 32'h5A5A_FFFC);
    exp_fetch(32'h0000_0000, 32'hA5A5_0000);
    accept_left  = 2;
    mem_ready_en = 1'b1;
    wait_drain("t5_drain", 20);

    // 6: 3 buffered + 1 in flight flushed by a redirect
    do_reset();
    mem_lat      = 2;
    mem_ready_en = 1'b1;
    accept_left  = 4;
    addr_exp_q.push_back(32'h0000_0000);
    addr_exp_q.push_back(32'h0000_0004);
    addr_exp_q.push_back(32'h0000_0008);
    addr_exp_q.push_back(32'h0000_000C);
    wait_for("t6_wait_full3", IF_WAIT, 3, 40);
    redirect(32'h0000_0040);
    check("t6_count_cleared", 32'(dbg.fifo_count), 32'd0);
    check("t6_state_drop", 32'(dbg.state), 32'(IF_DROP));
    check("t6_dec_valid", 32'(bus.dec_valid), 32'd0);
`ifdef FETCH_PERF_EN
    check("t6_perf_fetched", bus.perf_fetched, 32'd3);
    check("t6_perf_flushed", bus.perf_flushed, 32'd4);
`else
    check("t6_perf_fetched", bus.perf_fetched, 32'd0);
    check("t6_perf_flushed", bus.perf_flushed, 32'd0);
`endif
    repeat (6) tick();
    check("t6_state_req", 32'(dbg.state), 32'(IF_REQ));
    check("t6_restart_addr", bus.imem_addr, 32'h0000_0040);
    check("t6_dec_valid_after", 32'(bus.dec_valid), 32'd0);
    check("t6_addr_q_empty", 32'(addr_exp_q.size()), 32'd0);
    check("t6_exp_q_empty", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
